arbiter: RTL and testbench
==========================

ARBITER -- requirements
Module: arbiter

Interface
- REQ-001 SHALL have parameter NUM_REQ, default 4: number of requestors (2..8).
- REQ-002 SHALL have parameter ACCESS_CYCLES, default 4: clocks per granted access (1..16).
- REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
- REQ-004 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port req_i, input, NUM_REQ: per-requestor access request, level, held until done.
- REQ-006 SHALL have port grant_o, output, NUM_REQ: one-hot grant, zero when idle.
- REQ-007 SHALL have port grant_idx_o, output, $clog2(NUM_REQ): index of current or last grant.
- REQ-008 SHALL have port strobe_o, output, 1: one-clock pulse in the first cycle of each access.
- REQ-009 SHALL have port done_o, output, NUM_REQ: one-hot, one-clock pulse in the last cycle of an access.
- REQ-010 SHALL have port busy_o, output, 1: high whenever grant_o is non-zero.

Function
- REQ-011 SHALL implement states IDLE and ACCESS, plus a down-counter of width $clog2(ACCESS_CYCLES)+1.
- REQ-012 In IDLE with any req_i bit high at a rising edge, that edge SHALL select a winner, set grant_o, grant_idx_o and strobe_o, load the counter with ACCESS_CYCLES-1, and enter ACCESS.
- REQ-013 In IDLE with req_i all zero, outputs SHALL stay zero and the state SHALL remain IDLE.
- REQ-014 In ACCESS, grant_o and grant_idx_o SHALL hold constant for exactly ACCESS_CYCLES clocks.
- REQ-015 strobe_o SHALL be high only in the first ACCESS clock.
- REQ-016 done_o[winner] SHALL be high only in the last ACCESS clock, when the counter equals 0.
- REQ-017 With ACCESS_CYCLES=1, strobe_o and done_o SHALL be high in the same clock.
- REQ-018 The edge ending the last ACCESS clock SHALL clear grant_o and return to IDLE.
- REQ-019 At least one IDLE clock SHALL separate consecutive grants, giving a minimum period of ACCESS_CYCLES+1 clocks.
- REQ-020 Deasserting req_i during ACCESS SHALL NOT abort the access; it completes and done_o still pulses.
- REQ-021 A requestor still asserting req_i in the IDLE clock after its done SHALL be eligible again under the selection rule.
- REQ-022 grant_idx_o SHALL retain the last winner while idle.
- REQ-023 req_i changes during ACCESS SHALL be ignored until IDLE.

Reset
- REQ-024 reset_n_i low SHALL immediately force IDLE, counter 0, grant_o=0, strobe_o=0, done_o=0, busy_o=0, grant_idx_o=0 and the round-robin pointer to 0.
- REQ-025 Reset asserted mid-access SHALL abandon the access with no done_o pulse.
- REQ-026 The first grant after reset release SHALL occur no earlier than the first rising edge with reset_n_i high.

Configuration
- REQ-027 With macro ARBITER_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index found searching upward, with wrap, from (last winner + 1) mod NUM_REQ.
- REQ-028 Without ARBITER_ROUND_ROBIN_EN, the winner SHALL be the lowest requesting index (fixed priority), and the pointer logic SHALL be absent.

Structure
- REQ-029 Package arbiter_pkg SHALL hold the state enum typedef (IDLE, ACCESS) and the default constants for NUM_REQ and ACCESS_CYCLES.
- REQ-030 Winner selection SHALL be a purely combinational sub-module arbiter_pick (inputs: req vector, start index; outputs: one-hot grant, index, valid).

Verification (NUM_REQ=4, ACCESS_CYCLES=4)
- REQ-031 Single request: req_i=0010 -> grant_o=0010 for 4 clocks, strobe_o in clock 1, done_o=0010 in clock 4, then grant_o=0000.
- REQ-032 Simultaneous requests: req_i=1010 held, fixed priority -> grants 0010, 0010, 0010, each 5 clocks apart.
- REQ-033 Same stimulus with ARBITER_ROUND_ROBIN_EN -> grants alternate 0010, 1000, 0010.
- REQ-034 Request drop: req_i=0001 for one clock only -> full 4-clock access and done_o=0001 still occur.
- REQ-035 Reset mid-access: reset_n_i low in access clock 2 -> all outputs 0 at once, no done_o; after release with req_i=0100 -> grant_o=0100.
- REQ-036 Idle: req_i=0000 for 20 clocks -> busy_o, strobe_o, done_o and grant_o stay 0.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and default sizing for the arbiter block.
package arbiter_pkg;

    // Default number of requestors (2..8).
    localparam int DEF_NUM_REQ       = 4;
    // Default clocks per granted access (1..16).
    localparam int DEF_ACCESS_CYCLES = 4;

    // Arbiter control states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage : arbiter_pkg

// File: rtl/arbiter_pick.sv
// Combinational winner selection: the first requesting index found by
// searching upward from start_i, wrapping past the top index.
// A start_i of zero degenerates to plain lowest-index priority.
module arbiter_pick
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Two passes: first look at indices at or above start_i, then wrap
    // around to the lowest requesting index below it.
    always_comb begin
        // NOTE: every output gets a default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (IDX_W'(i) >= start_i)) begin
                valid_o    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
    end

endmodule : arbiter_pick

// File: rtl/arbiter.sv
// Access arbiter: grants one requestor at a time for ACCESS_CYCLES clocks,
// with at least one IDLE clock between grants.
// Define ARBITER_ROUND_ROBIN_EN for round-robin selection; otherwise the
// lowest requesting index always wins (fixed priority).
module arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       strobe_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ACCESS_CYCLES) + 1;
    // Counter value in the first access clock; reaches zero in the last.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [IDX_W-1:0]     start_idx;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

`ifdef ARBITER_ROUND_ROBIN_EN
    // Search starts one above the last winner so every requestor gets a turn.
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign start_idx = ptr_q;

    // Advance the pointer past the winner on each new grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid) begin
            ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: always search from index 0.
    assign start_idx = '0;
`endif

    arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .start_i (start_idx),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Next-state logic: pick a winner from IDLE, count down in ACCESS.
    // Requests are only looked at in IDLE, so changes during an access
    // (including a dropped request) never disturb it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last access clock ends here; grant_idx keeps the winner.
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decoded from registered state only. With ACCESS_CYCLES=1 the
    // load value is zero, so strobe and done coincide in the single clock.
    always_comb begin
        grant_o     = grant_q;
        grant_idx_o = idx_q;
        busy_o      = |grant_q;
        strobe_o    = (state_q == ACCESS) && (cnt_q == CNT_LOAD);
        done_o      = ((state_q == ACCESS) && (cnt_q == '0)) ? grant_q : '0;
    end

endmodule : arbiter

// File: tb/tb_arbiter.sv
// Self-checking bench for arbiter (NUM_REQ=4, ACCESS_CYCLES=4).
// Expected grants are queued when stimulus is driven and popped when
// strobe_o marks the start of an access. Honours ARBITER_ROUND_ROBIN_EN.
module tb_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int ACCESS_CYCLES = 4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic [3:0] req_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic       strobe_o;
    logic [3:0] done_o;
    logic       busy_o;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx_o),
        .strobe_o    (strobe_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycle++;

    // Wait (bounded) for the first access clock; leaves us at that negedge.
    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (strobe_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        req_i     = 4'b0000;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    // Pop the queued expectation and compare with the live grant.
    task automatic pop_and_compare(input string name);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: strobe with empty scoreboard, got grant=%b", name, grant_o);
        end else begin
            e = exp_q.pop_front();
            if ({grant_o, grant_idx_o} !== {e.grant, e.idx}) begin
                bad++;
                $display("FAIL %s: got grant=%b idx=%0d, want grant=%b idx=%0d",
                         name, grant_o, grant_idx_o, e.grant, e.idx);
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        req_i     = 4'b1111;
        reset_n_i = 1'b1;
        #1 reset_n_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            total++;
            if ({grant_o, grant_idx_o, strobe_o, done_o, busy_o} !== 12'b0) begin
                bad++;
                $display("FAIL reset_outputs: got grant=%b idx=%0d strobe=%b done=%b busy=%b, want all 0",
                         grant_o, grant_idx_o, strobe_o, done_o, busy_o);
            end
        end
        // Release with requests pending: no grant before the next rising edge.
        reset_n_i = 1'b1;
        exp_q.push_back('{grant: 4'b0001, idx: 2'd0});
        #1;
        total++;
        if (grant_o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release_early: got grant=%b, want 0000", grant_o);
        end
        wait_strobe(1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_first_grant: no strobe on first edge after release, want grant=0001");
        end else begin
            total--;
            pop_and_compare("reset_first_grant");
        end
        req_i = 4'b0000;
        repeat (5) @(negedge clk_i);
    endtask

    task automatic test_single();
        bit ok;
        req_i = 4'b0010;
        exp_q.push_back('{grant: 4'b0010, idx: 2'd1});
        wait_strobe(3, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout: no strobe seen, want grant=0010");
            exp_q.delete();
            return;
        end
        total--;
        pop_and_compare("single_grant");
        for (int c = 1; c <= ACCESS_CYCLES; c++) begin
            if (c > 1) @(negedge clk_i);
            total++;
            if ({grant_o, busy_o, strobe_o, done_o} !==
                {4'b0010, 1'b1, (c == 1), (c == ACCESS_CYCLES) ? 4'b0010 : 4'b0000}) begin
                bad++;
                $display("FAIL single_clk%0d: got grant=%b busy=%b strobe=%b done=%b", c,
                         grant_o, busy_o, strobe_o, done_o);
            end
            if (c == ACCESS_CYCLES) req_i = 4'b0000;
        end
        @(negedge clk_i);
        total++;
        if ({grant_o, busy_o, done_o} !== 9'b0) begin
            bad++;
            $display("FAIL single_end: got grant=%b busy=%b done=%b, want 0", grant_o, busy_o, done_o);
        end
        repeat (3) @(negedge clk_i);
        total++;
        if (grant_idx_o !== 2'd1) begin
            bad++;
            $display("FAIL idx_retain: got idx=%0d, want 1", grant_idx_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int prev;
        apply_reset();
        req_i = 4'b1010;
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_q.push_back('{grant: 4'b0010, idx: 2'd1});
        exp_q.push_back('{grant: 4'b1000, idx: 2'd3});
        exp_q.push_back('{grant: 4'b0010, idx: 2'd1});
`else
        exp_q.push_back('{grant: 4'b0010, idx: 2'd1});
        exp_q.push_back('{grant: 4'b0010, idx: 2'd1});
        exp_q.push_back('{grant: 4'b0010, idx: 2'd1});
`endif
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(8, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b_timeout%0d: no strobe seen", k);
                exp_q.delete();
                break;
            end
            total--;
            pop_and_compare($sformatf("b2b_grant%0d", k));
            if (prev >= 0) begin
                total++;
                if (cycle - prev !== ACCESS_CYCLES + 1) begin
                    bad++;
                    $display("FAIL b2b_period%0d: got %0d clocks, want %0d", k, cycle - prev,
                             ACCESS_CYCLES + 1);
                end
            end
            prev = cycle;
        end
        req_i = 4'b0000;
        repeat (5) @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got busy=%b, want 0", busy_o);
        end
    endtask

    task automatic test_drop();
        bit ok;
        req_i = 4'b0001;
        exp_q.push_back('{grant: 4'b0001, idx: 2'd0});
        wait_strobe(3, ok);
        req_i = 4'b0000;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drop_timeout: no strobe seen, want grant=0001");
            exp_q.delete();
            return;
        end
        total--;
        pop_and_compare("drop_grant");
        for (int c = 2; c <= ACCESS_CYCLES; c++) begin
            @(negedge clk_i);
            total++;
            if ({grant_o, done_o} !== {4'b0001, (c == ACCESS_CYCLES) ? 4'b0001 : 4'b0000}) begin
                bad++;
                $display("FAIL drop_clk%0d: got grant=%b done=%b", c, grant_o, done_o);
            end
        end
        @(negedge clk_i);
        total++;
        if (grant_o !== 4'b0000) begin
            bad++;
            $display("FAIL drop_end: got grant=%b, want 0000", grant_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        req_i = 4'b0001;
        exp_q.push_back('{grant: 4'b0001, idx: 2'd0});
        wait_strobe(3, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_timeout: no strobe seen, want grant=0001");
            exp_q.delete();
        end else begin
            total--;
            pop_and_compare("rstmid_grant");
        end
        @(negedge clk_i);
        reset_n_i = 1'b0;
        req_i     = 4'b0100;
        #1;
        total++;
        if ({grant_o, grant_idx_o, strobe_o, done_o, busy_o} !== 12'b0) begin
            bad++;
            $display("FAIL rstmid_clear: got grant=%b idx=%0d strobe=%b done=%b busy=%b, want all 0",
                     grant_o, grant_idx_o, strobe_o, done_o, busy_o);
        end
        repeat (2) begin
            @(negedge clk_i);
            total++;
            if (done_o !== 4'b0000) begin
                bad++;
                $display("FAIL rstmid_nodone: got done=%b, want 0000", done_o);
            end
        end
        reset_n_i = 1'b1;
        exp_q.push_back('{grant: 4'b0100, idx: 2'd2});
        wait_strobe(3, ok);
        req_i = 4'b0000;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_regrant: no strobe after release, want grant=0100");
            exp_q.delete();
        end else begin
            total--;
            pop_and_compare("rstmid_regrant");
        end
        repeat (5) @(negedge clk_i);
    endtask

    task automatic test_idle();
        req_i = 4'b0000;
        repeat (20) begin
            @(negedge clk_i);
            total++;
            if ({busy_o, strobe_o, done_o, grant_o} !== 10'b0) begin
                bad++;
                $display("FAIL idle: got busy=%b strobe=%b done=%b grant=%b, want all 0",
                         busy_o, strobe_o, done_o, grant_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_arbiter
